// File: rtl/channel_scanner_pkg.sv
// Shared types and sizing for the channel scanner that sequences the 6-way 4-bit mux.
// The unused select code SEL_PARK makes the mux output zero while no scan is running.
package scanner_pkg;
  localparam int NUM_CH  = 6;
  localparam int SEL_W   = 3;
  localparam int DATA_W  = 4;
  localparam int DWELL_W = 4;

  localparam logic [SEL_W-1:0] SEL_PARK = 3'b110;

  typedef enum logic [1:0] {IDLE, SETTLE, EMIT, DONE} state_t;

  function automatic logic [NUM_CH-1:0] ch_bit(input logic [SEL_W-1:0] ch);
    return NUM_CH'(1) << ch;
  endfunction
endpackage

// File: rtl/channel_scanner_if.sv
// Control, mux-side and output-stream signals of the channel scanner.
interface channel_scanner_if;
  import scanner_pkg::*;

  logic              start;
  logic [NUM_CH-1:0] ch_mask;
  logic [DWELL_W-1:0] dwell;
  logic [SEL_W-1:0]  sel;
  logic [DATA_W-1:0] mux_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [SEL_W-1:0]  out_ch;
  logic              busy;
  logic              done;

  modport master (
    input  start, ch_mask, dwell, mux_data, out_ready,
    output sel, out_valid, out_data, out_ch, busy, done
  );

  modport slave (
    output start, ch_mask, dwell, mux_data, out_ready,
    input  sel, out_valid, out_data, out_ch, busy, done
  );
endinterface

// File: rtl/channel_scanner_lowest_set_bit.sv
// Priority encoder: index of the lowest set bit of a channel mask, plus a non-empty flag.
module lowest_set_bit
  import scanner_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  output logic [SEL_W-1:0]  idx,
  output logic              any
);

  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i]) begin
        idx = SEL_W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/channel_scanner.sv
// Walks the enabled mux channels in ascending order, waits the settle time on each,
// and hands every captured sample to a valid/ready stream.
module channel_scanner
  import scanner_pkg::*;
(
  input logic clk,
  input logic areset_n,
  channel_scanner_if.master bus
);

  state_t             state, state_nxt;
  logic [NUM_CH-1:0]  pending;
  logic [NUM_CH-1:0]  remaining;
  logic [DWELL_W-1:0] cnt;
  logic [DWELL_W-1:0] dwell_r;
  logic [SEL_W-1:0]   sel_r;
  logic [SEL_W-1:0]   out_ch_r;
  logic [DATA_W-1:0]  out_data_r;
  logic               done_r;
  logic [SEL_W-1:0]   first_idx, next_idx;
  logic               first_any, next_any;

  // Channels still to visit once the current one has been handed off.
  assign remaining = pending & ~ch_bit(sel_r);

  lowest_set_bit u_first (
    .mask (bus.ch_mask),
    .idx  (first_idx),
    .any  (first_any)
  );

  lowest_set_bit u_next (
    .mask (remaining),
    .idx  (next_idx),
    .any  (next_any)
  );

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start && first_any) state_nxt = SETTLE;
      SETTLE:  if (cnt == '0) state_nxt = EMIT;
      EMIT:    if (bus.out_ready) state_nxt = next_any ? SETTLE : DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Mask and dwell are latched at scan start so later input changes cannot disturb a scan.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      pending    <= '0;
      cnt        <= '0;
      dwell_r    <= '0;
      sel_r      <= SEL_PARK;
      out_data_r <= '0;
      out_ch_r   <= '0;
      done_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (first_any) begin
              pending <= bus.ch_mask;
              cnt     <= bus.dwell;
              dwell_r <= bus.dwell;
              sel_r   <= first_idx;
            end else begin
              done_r  <= 1'b1;
            end
          end
        end
        SETTLE: begin
          if (cnt != '0) begin
            cnt <= cnt - DWELL_W'(1);
          end else begin
            out_data_r <= bus.mux_data;
            out_ch_r   <= sel_r;
          end
        end
        EMIT: begin
          if (bus.out_ready) begin
            pending <= remaining;
            if (next_any) begin
              sel_r <= next_idx;
              cnt   <= dwell_r;
            end else begin
              sel_r  <= SEL_PARK;
              done_r <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.sel       = sel_r;
  assign bus.out_valid = (state == EMIT);
  assign bus.out_data  = out_data_r;
  assign bus.out_ch    = out_ch_r;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_r;

endmodule

// File: doc/channel_scanner.md
Name: channel_scanner

Overview:
- Sequencer that sits directly upstream of the 6-way 4-bit channel mux.
- It drives the mux select and samples the returned mux data.
- On a start pulse it walks every enabled channel in ascending index order, waits a programmable settle time on each, then presents each sample on a valid/ready output stream.
- It makes the mux usable as a scanned acquisition front end.

Parameters:
- NUM_CH, 6: number of mux channels scanned.
- SEL_W, 3: select width, equal to the mux select width.
- DATA_W, 4: mux data width.
- DWELL_W, 4: width of the settle counter.

Ports:
- clk  input  1  single clock, rising edge.
- areset_n  input  1  asynchronous active-low reset.
- start  input  1  scan request, sampled in IDLE only.
- ch_mask  input  NUM_CH  channel enable mask; bit i enables channel i.
- dwell  input  DWELL_W  settle cycles per channel after sel changes.
- sel  output  SEL_W  select driven to the mux.
- mux_data  input  DATA_W  combinational data returned by the mux.
- out_valid  output  1  sample available.
- out_ready  input  1  downstream accepts the sample.
- out_data  output  DATA_W  captured sample.
- out_ch  output  SEL_W  channel index of out_data.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse at scan end.

Behaviour:
- Interface: one clock (clk); asynchronous active-low reset (areset_n).
- Reset (asynchronous, immediate, also mid-scan):
  - state=IDLE.
  - sel=SEL_PARK (3'b110, an unused mux code, so the mux outputs 0).
  - out_valid=0, out_data=0, out_ch=0, busy=0, done=0.
  - pending mask=0, counter=0.
- IDLE:
  - start=1 and ch_mask!=0: latch pending=ch_mask and cnt=dwell; sel=index of lowest set bit; go to SETTLE.
  - start=1 and ch_mask==0: done pulses for 1 cycle; stay in IDLE; sel stays parked.
- SETTLE:
  - Each edge with cnt!=0: cnt decrements.
  - Edge with cnt==0: out_data<=mux_data, out_ch<=sel, out_valid<=1; go to EMIT.
  - Latency: after the edge that sets sel, out_valid rises dwell+1 edges later (dwell=0 gives 1 edge).
- EMIT:
  - out_valid, out_data and out_ch are held stable until out_ready=1 at an edge.
  - On that edge: out_valid<=0 and the current bit is cleared from pending.
  - If the remaining pending!=0: sel=next lowest set bit, cnt=dwell, go to SETTLE.
  - Otherwise: sel=SEL_PARK, go to DONE.
  - out_ready may already be high when out_valid rises; the handshake then completes on the next edge.
  - out_ready while out_valid=0 is ignored.
- DONE: done=1 for exactly one cycle, busy=1; then go to IDLE.
- start while busy is ignored.
- ch_mask and dwell are sampled only at scan start; later changes do not affect the running scan.
- Mask bits above NUM_CH-1 do not exist; sel never reaches 3'b110 or 3'b111 except as the park value.
- dwell at max (15) gives 16 sample edges per channel; the counter never wraps.
- Scan order is ascending index. Each enabled channel is emitted exactly once per scan.

Decomposition:
- Package scanner_pkg:
  - state enum {IDLE, SETTLE, EMIT, DONE}.
  - SEL_PARK=3'b110.
  - NUM_CH, SEL_W, DATA_W defaults.
- One combinational sub-module, lowest_set_bit: NUM_CH-bit mask in; index (SEL_W) and any flag out. Used both at start and after each handshake.

Test Plan:
- Reset check: areset_n=0 mid-scan (state SETTLE, sel=2) -> same cycle sel=3'b110, out_valid=0, busy=0; no done pulse after release.
- Full scan: ch_mask=6'b111111, dwell=0, out_ready=1, mux model returns data=ch+4'h8 -> six samples (ch,data) = (0,8),(1,9),(2,A),(3,B),(4,C),(5,D) in order; done pulse one cycle after the last handshake.
- Sparse mask with dwell: ch_mask=6'b100100, dwell=3 -> sel=2 for 4 sample edges, then emits (2,...); then sel=5, then emits (5,...); sel returns to 3'b110.
- Backpressure: out_ready=0 for 10 cycles during EMIT -> out_valid, out_data and out_ch are stable; sel is unchanged; on the out_ready edge the next channel is selected.
- Empty mask: start with ch_mask=0 -> done=1 for one cycle; busy stays 0; out_valid stays 0.
- Ignored inputs: start re-asserted and ch_mask changed to 6'b000001 mid-scan of 6'b001010 -> only channels 1 and 3 are emitted; a single done pulse.
